// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared definitions for the vending-machine datapath.
//                Arbiter FSM state encoding and coin-channel indices, used by
//                the coin pulse conditioner and the downstream vending FSM.
//  Revision    : 1.0  initial release
// ============================================================================
package vend_pkg;

    // Pulse arbiter states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Coin channel indices; dollar has arbitration priority
    localparam int COIN_DOLLAR  = 0;
    localparam int COIN_QUARTER = 1;
    localparam int NUM_COINS    = 2;

endpackage
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : coin_debounce
//  Description : One coin-sensor channel: 2-flop synchroniser, debounce
//                counter, debounced rise detect and high-time (jam) counter.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk     in   system clock
//    reset   in   asynchronous active-high reset
//    raw_in  in   raw sensor level, asynchronous, may bounce
//    rise    out  debounced level went 0->1 this cycle
//    jam_d   out  next-cycle value of this channel's jam condition
// ============================================================================
module coin_debounce
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int JAM_CYCLES      = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic rise,
    output logic jam_d
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int JAM_W = $clog2(JAM_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [JAM_W-1:0] JAM_MAX = JAM_W'(JAM_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [DB_W-1:0]  db_cnt_d;
    logic [JAM_W-1:0] jam_cnt_q;
    logic [JAM_W-1:0] jam_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            db_cnt_q     <= '0;
            jam_cnt_q    <= '0;
        end else begin
            sync1_q      <= raw_in;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            db_cnt_q     <= db_cnt_d;
            jam_cnt_q    <= jam_cnt_d;
        end
    end

    always_comb begin
        level_d   = level_q;
        db_cnt_d  = '0;
        jam_cnt_d = '0;
        // The counter only runs while the synced value disagrees with the
        // accepted level; any return to agreement (a bounce) reloads it.
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_MAX) begin
                level_d  = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        // High-time counter saturates so a long jam never wraps back to clear
        if (level_q) begin
            jam_cnt_d = (jam_cnt_q == JAM_MAX) ? jam_cnt_q : jam_cnt_q + 1'b1;
        end
    end

    assign rise  = level_q & ~level_prev_q;
    assign jam_d = (jam_cnt_d == JAM_MAX);

endmodule
`default_nettype wire

// File: rtl/coin_pulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pulse_conditioner
//  Description : Debounces the dollar/quarter coin sensors and issues clean,
//                mutually exclusive one-cycle coin pulses separated by an idle
//                lockout gap. Coincident coins are serialised, dollar first.
//                Reports jammed sensors and dropped coin edges.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          in   system clock, posedge
//    reset        in   asynchronous active-high reset
//    dollar_raw   in   raw dollar sensor
//    quarter_raw  in   raw quarter sensor
//    dollar       out  one-cycle pulse, one dollar accepted
//    quarter      out  one-cycle pulse, one quarter accepted
//    jam          out  level, a debounced sensor is stuck high
//    overrun      out  one-cycle pulse, a coin edge was dropped
// ============================================================================
module coin_pulse_conditioner
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 4,
    parameter int JAM_CYCLES      = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic dollar_raw,
    input  logic quarter_raw,
    output logic dollar,
    output logic quarter,
    output logic jam,
    output logic overrun
);

    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic [NUM_COINS-1:0] raw_vec;
    logic [NUM_COINS-1:0] rise;
    logic [NUM_COINS-1:0] chan_jam_d;
    logic [NUM_COINS-1:0] grant;
    logic [NUM_COINS-1:0] pending_q;
    logic [NUM_COINS-1:0] pending_d;
    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [LOCK_W-1:0]    lock_cnt_q;
    logic [LOCK_W-1:0]    lock_cnt_d;
    logic                 arbitrate;
    logic                 dollar_q,  dollar_d;
    logic                 quarter_q, quarter_d;
    logic                 jam_q,     jam_d;
    logic                 overrun_q, overrun_d;

    assign raw_vec[COIN_DOLLAR]  = dollar_raw;
    assign raw_vec[COIN_QUARTER] = quarter_raw;

    generate
        for (genvar g = 0; g < NUM_COINS; g++) begin : g_chan
            coin_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .JAM_CYCLES      (JAM_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .raw_in (raw_vec[g]),
                .rise   (rise[g]),
                .jam_d  (chan_jam_d[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            pending_q  <= '0;
            dollar_q   <= 1'b0;
            quarter_q  <= 1'b0;
            jam_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            pending_q  <= pending_d;
            dollar_q   <= dollar_d;
            quarter_q  <= quarter_d;
            jam_q      <= jam_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        grant      = '0;
        arbitrate  = 1'b0;

        case (state_q)
            IDLE: arbitrate = 1'b1;
            EMIT: begin
                state_d    = GAP;
                lock_cnt_d = '0;
            end
            GAP: begin
                // Arbitrate in the last gap cycle so a queued coin follows
                // the lockout with no extra idle cycle.
                if (lock_cnt_q == LOCK_LAST) begin
                    arbitrate = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arbitrate) begin
            state_d = IDLE;
            if (pending_q[COIN_DOLLAR]) begin
                grant[COIN_DOLLAR] = 1'b1;
            end else if (pending_q[COIN_QUARTER]) begin
                grant[COIN_QUARTER] = 1'b1;
            end
            if (|grant) begin
                state_d = EMIT;
            end
        end

        // Grant clears the pending bit on the same edge the pulse is issued,
        // so an edge arriving then re-arms the slot instead of overrunning.
        pending_d = (pending_q & ~grant) | rise;
        overrun_d = |(rise & pending_q & ~grant);
        dollar_d  = grant[COIN_DOLLAR];
        quarter_d = grant[COIN_QUARTER];
        jam_d     = |chan_jam_d;
    end

    assign dollar  = dollar_q;
    assign quarter = quarter_q;
    assign jam     = jam_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_pulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_pulse_conditioner
//  Description : Self-checking bench. Two instances share the raw inputs: a
//                short-lockout one and a long-lockout one that lets coin
//                edges pile up on a pending slot. A behavioural model derives
//                the debounced levels from windows of raw samples and issues
//                pulses from a next-free-slot schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coin_pulse_conditioner;

    localparam int DB      = 4;
    localparam int LK      = 2;
    localparam int LK_LONG = 24;
    localparam int JM      = 20;
    localparam int NINST   = 2;
    localparam int HMAX    = 8192;

    logic             clk = 1'b0;
    logic             reset;
    logic             dollar_raw;
    logic             quarter_raw;
    logic [NINST-1:0] dollar, quarter, jam, overrun;

    coin_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DB), .LOCKOUT_CYCLES (LK), .JAM_CYCLES (JM)
    ) u_dut (
        .clk (clk), .reset (reset), .dollar_raw (dollar_raw), .quarter_raw (quarter_raw),
        .dollar (dollar[0]), .quarter (quarter[0]), .jam (jam[0]), .overrun (overrun[0])
    );

    coin_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DB), .LOCKOUT_CYCLES (LK_LONG), .JAM_CYCLES (JM)
    ) u_dut_long (
        .clk (clk), .reset (reset), .dollar_raw (dollar_raw), .quarter_raw (quarter_raw),
        .dollar (dollar[1]), .quarter (quarter[1]), .jam (jam[1]), .overrun (overrun[1])
    );

    always #5 clk = ~clk;

    // Reference model state
    int  t    = 8;
    int  base = 8;
    bit  raw_h [2][HMAX];
    bit  deb_h [2][HMAX];
    int  run   [2];
    bit  pend  [NINST][2];
    int  next_free [NINST];
    bit  exp_d [NINST], exp_q [NINST], exp_j [NINST], exp_o [NINST];

    // Observation tallies for directed scenario checks
    int  t0;
    int  d_cnt [NINST], q_cnt [NINST], o_cnt [NINST];
    int  d_first [NINST], q_first [NINST], o_first [NINST];
    int  jam_first, jam_fall;
    bit  jam_prev;

    int  n_assert = 0;
    int  n_fail   = 0;

    function automatic int lockout_of(int i);
        return (i == 0) ? LK : LK_LONG;
    endfunction

    function automatic bit raw_at(int ch, int k);
        if (k < base) return 1'b0;
        return raw_h[ch][k];
    endfunction

    task automatic chk(string tag, logic obs, logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, t, obs, expv);
        end
    endtask

    task automatic chk_int(string tag, int obs, int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            deb_h[ch][t]   = 1'b0;
            deb_h[ch][t-1] = 1'b0;
            run[ch]        = 0;
        end
        for (int i = 0; i < NINST; i++) begin
            pend[i][0] = 1'b0; pend[i][1] = 1'b0;
            next_free[i] = 0;
            exp_d[i] = 1'b0; exp_q[i] = 1'b0; exp_j[i] = 1'b0; exp_o[i] = 1'b0;
        end
        base = t + 1;
    endtask

    task automatic model_cycle();
        bit rise [2];
        bit jam_now;
        jam_now = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            // Accept a level once D+1 consecutive synchronised samples agree
            bit v, same;
            v    = raw_at(ch, t - 2);
            same = 1'b1;
            for (int k = t - 2 - DB; k <= t - 2; k++)
                if (raw_at(ch, k) != v) same = 1'b0;
            deb_h[ch][t] = same ? v : deb_h[ch][t-1];
            rise[ch]     = deb_h[ch][t-1] && !deb_h[ch][t-2];
            run[ch]      = deb_h[ch][t-1] ? run[ch] + 1 : 0;
            if (run[ch] >= JM) jam_now = 1'b1;
        end
        for (int i = 0; i < NINST; i++) begin
            bit g [2];
            g[0] = 1'b0; g[1] = 1'b0;
            exp_o[i] = 1'b0;
            if (t >= next_free[i]) begin
                if (pend[i][0]) g[0] = 1'b1;
                else if (pend[i][1]) g[1] = 1'b1;
            end
            if (g[0] || g[1]) next_free[i] = t + lockout_of(i) + 1;
            for (int ch = 0; ch < 2; ch++) begin
                if (g[ch]) pend[i][ch] = 1'b0;
                if (rise[ch]) begin
                    if (pend[i][ch]) exp_o[i] = 1'b1;
                    pend[i][ch] = 1'b1;
                end
            end
            exp_d[i] = g[0];
            exp_q[i] = g[1];
            exp_j[i] = jam_now;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NINST; i++) begin
            chk($sformatf("dollar[%0d]", i),  dollar[i],  exp_d[i]);
            chk($sformatf("quarter[%0d]", i), quarter[i], exp_q[i]);
            chk($sformatf("jam[%0d]", i),     jam[i],     exp_j[i]);
            chk($sformatf("overrun[%0d]", i), overrun[i], exp_o[i]);
            chk($sformatf("exclusive[%0d]", i), dollar[i] & quarter[i], 1'b0);
        end
    endtask

    task automatic clear_tally();
        t0 = t + 1;
        for (int i = 0; i < NINST; i++) begin
            d_cnt[i] = 0; q_cnt[i] = 0; o_cnt[i] = 0;
            d_first[i] = -1; q_first[i] = -1; o_first[i] = -1;
        end
        jam_first = -1; jam_fall = -1; jam_prev = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        raw_h[0][t] = dollar_raw;
        raw_h[1][t] = quarter_raw;
        if (reset) model_reset();
        else       model_cycle();
        #1;
        check_outputs();
        for (int i = 0; i < NINST; i++) begin
            if (dollar[i])  begin d_cnt[i]++; if (d_first[i] < 0) d_first[i] = t - t0; end
            if (quarter[i]) begin q_cnt[i]++; if (q_first[i] < 0) q_first[i] = t - t0; end
            if (overrun[i]) begin o_cnt[i]++; if (o_first[i] < 0) o_first[i] = t - t0; end
        end
        if (jam[0] && jam_first < 0) jam_first = t - t0;
        if (!jam[0] && jam_prev && jam_fall < 0) jam_fall = t - t0;
        jam_prev = jam[0];
    endtask

    task automatic drive(bit d, bit q, int n);
        dollar_raw  = d;
        quarter_raw = q;
        repeat (n) step();
    endtask

    task automatic reset_pulse(int n);
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        int s;
        dollar_raw  = 1'b0;
        quarter_raw = 1'b0;
        clear_tally();

        // Reset state
        reset_pulse(3);
        drive(0, 0, 10);

        // 1: clean quarter, held 10 cycles
        clear_tally();
        drive(0, 1, 10);
        chk_int("t1 quarter cycle", q_first[0], 8);
        chk_int("t1 quarter count", q_cnt[0], 1);
        chk_int("t1 dollar count", d_cnt[0], 0);
        drive(0, 0, 50);

        // 2: bouncing quarter then settle high
        drive(0, 1, 1); drive(0, 0, 1); drive(0, 1, 1); drive(0, 0, 1);
        clear_tally();
        drive(0, 1, 12);
        chk_int("t2 quarter after settle", q_first[0], 8);
        drive(0, 0, 50);
        chk_int("t2 quarter count", q_cnt[0], 1);

        // 3: simultaneous dollar and quarter
        clear_tally();
        drive(1, 1, 14);
        chk_int("t3 dollar cycle", d_first[0], 8);
        chk_int("t3 quarter cycle", q_first[0], 11);
        drive(0, 0, 50);

        // 4: repeated quarter edges against the long-lockout instance
        clear_tally();
        drive(0, 1, 8);
        drive(0, 0, 5); drive(0, 1, 5);
        drive(0, 0, 5); drive(0, 1, 5);
        drive(0, 0, 40);
        chk_int("t4 long quarter count", q_cnt[1], 2);
        chk_int("t4 long overrun count", o_cnt[1], 1);
        chk_int("t4 long overrun cycle", o_first[1], 30);
        chk_int("t4 long second quarter", q_cnt[1] > 0 ? 33 : -1, 33);
        chk_int("t4 short quarter count", q_cnt[0], 3);
        chk_int("t4 short overrun count", o_cnt[0], 0);

        // 5: dollar held 30 cycles -> jam
        clear_tally();
        drive(1, 0, 30);
        drive(0, 0, 15);
        chk_int("t5 dollar count", d_cnt[0], 1);
        chk_int("t5 jam rise", jam_first, 26);
        chk_int("t5 jam fall", jam_fall, 37);
        drive(0, 0, 40);

        // 6: reset during EMIT of a queued pair
        clear_tally();
        drive(1, 1, 9);
        chk_int("t6 dollar cycle", d_first[0], 8);
        dollar_raw  = 1'b0;
        quarter_raw = 1'b0;
        reset_pulse(3);
        clear_tally();
        drive(0, 0, 30);
        chk_int("t6 quarter after reset", q_cnt[0] + q_cnt[1], 0);
        chk_int("t6 dollar after reset", d_cnt[0] + d_cnt[1], 0);

        // Randomised segments: bounce, holds, long holds, occasional reset
        for (int seg = 0; seg < 120; seg++) begin
            s = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 30) : $urandom_range(1, 12);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s);
            if ($urandom_range(0, 29) == 0) reset_pulse(2);
        end
        drive(0, 0, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
